// File: rtl/map_table_recovery_ctrl.sv
// rtl/map_table_recovery_ctrl.sv - branch recovery sequencer for the rename map table
// Frees or restores checkpoints, falls back to a youngest-first ROB walk, then rolls back the ROB tail.
module map_table_recovery_ctrl #(
    parameter int NUM_ARCH_REGS      = 32,
    parameter int NUM_PHYS_REGS      = 64,
    parameter int ROB_DEPTH          = 16,
    parameter int CHECKPOINT_COLUMNS = 4,
    localparam int AW = $clog2(NUM_ARCH_REGS),
    localparam int PW = $clog2(NUM_PHYS_REGS),
    localparam int RW = $clog2(ROB_DEPTH),
    localparam int CW = $clog2(CHECKPOINT_COLUMNS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          resolve_valid,
    input  logic          resolve_mispredict,
    input  logic [RW-1:0] resolve_ROB_index,
    input  logic          resolve_has_checkpoint,
    input  logic [CW-1:0] resolve_safe_column,
    input  logic [RW-1:0] rob_tail_index,
    output logic [RW-1:0] rob_read_index,
    input  logic          rob_read_dest_valid,
    input  logic [AW-1:0] rob_read_dest_arch_reg_tag,
    input  logic [PW-1:0] rob_read_safe_phys_reg_tag,
    input  logic [PW-1:0] rob_read_speculated_phys_reg_tag,
    output logic          revert_valid,
    output logic [AW-1:0] revert_dest_arch_reg_tag,
    output logic [PW-1:0] revert_safe_dest_phys_reg_tag,
    output logic [PW-1:0] revert_speculated_dest_phys_reg_tag,
    output logic          restore_checkpoint_valid,
    output logic          restore_checkpoint_speculate_failed,
    output logic [RW-1:0] restore_checkpoint_ROB_index,
    output logic [CW-1:0] restore_checkpoint_safe_column,
    input  logic          restore_checkpoint_success,
    output logic          rob_rollback_valid,
    output logic [RW-1:0] rob_rollback_tail_index,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREE_CKPT,
        S_RESTORE,
        S_WALK,
        S_DONE
    } state_t;

    localparam logic [RW-1:0] ONE = RW'(1);

    state_t        state_q;
    logic [RW-1:0] br_idx_q;
    logic [RW-1:0] walk_ptr_q;
    logic [CW-1:0] safe_col_q;

    logic [RW-1:0] tail_m1;
    logic [RW-1:0] br_plus1;
    logic          walking;
    logic          done;

    assign tail_m1  = rob_tail_index - ONE;
    assign br_plus1 = br_idx_q + ONE;
    assign walking  = (state_q == S_WALK);
    assign done     = (state_q == S_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            br_idx_q   <= '0;
            walk_ptr_q <= '0;
            safe_col_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (resolve_valid) begin
                        br_idx_q   <= resolve_ROB_index;
                        safe_col_q <= resolve_safe_column;
                        walk_ptr_q <= tail_m1;
                        if (!resolve_mispredict)
                            state_q <= resolve_has_checkpoint ? S_FREE_CKPT : S_IDLE;
                        else if (resolve_has_checkpoint)
                            state_q <= S_RESTORE;
                        else
                            state_q <= (tail_m1 == resolve_ROB_index) ? S_DONE : S_WALK;
                    end
                end
                S_FREE_CKPT: state_q <= S_IDLE;
                S_RESTORE: begin
                    // A refused restore means the checkpoint no longer matches; walk from the current tail.
                    if (restore_checkpoint_success) begin
                        state_q <= S_DONE;
                    end else begin
                        walk_ptr_q <= tail_m1;
                        state_q    <= (tail_m1 == br_idx_q) ? S_DONE : S_WALK;
                    end
                end
                S_WALK: begin
                    if (walk_ptr_q == br_plus1)
                        state_q <= S_DONE;
                    else
                        walk_ptr_q <= walk_ptr_q - ONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy                                = (state_q != S_IDLE);
    assign restore_checkpoint_valid            = (state_q == S_FREE_CKPT) || (state_q == S_RESTORE);
    assign restore_checkpoint_speculate_failed = (state_q == S_RESTORE);
    assign restore_checkpoint_ROB_index        = restore_checkpoint_valid ? br_idx_q : '0;
    assign restore_checkpoint_safe_column      = restore_checkpoint_valid ? safe_col_q : '0;

    assign rob_read_index                      = walking ? walk_ptr_q : '0;
    assign revert_valid                        = walking && rob_read_dest_valid;
    assign revert_dest_arch_reg_tag            = walking ? rob_read_dest_arch_reg_tag : '0;
    assign revert_safe_dest_phys_reg_tag       = walking ? rob_read_safe_phys_reg_tag : '0;
    assign revert_speculated_dest_phys_reg_tag = walking ? rob_read_speculated_phys_reg_tag : '0;

    assign rob_rollback_valid                  = done;
    assign rob_rollback_tail_index             = done ? br_plus1 : '0;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == S_FREE_CKPT)
                assert (restore_checkpoint_success);
            if (busy)
                assert (!resolve_valid);
            assert (!(revert_valid && restore_checkpoint_valid));
        end
    end

endmodule

// File: tb/tb_map_table_recovery_ctrl.sv
// tb/tb_map_table_recovery_ctrl.sv - self-checking bench for map_table_recovery_ctrl
// Per-cycle output traces are compared against a trace built from the recovery rules.
module tb_map_table_recovery_ctrl;

    localparam int L = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       resolve_valid = 1'b0;
    logic       resolve_mispredict = 1'b0;
    logic [3:0] resolve_ROB_index = '0;
    logic       resolve_has_checkpoint = 1'b0;
    logic [1:0] resolve_safe_column = '0;
    logic [3:0] rob_tail_index = '0;
    logic [3:0] rob_read_index;
    logic       rob_read_dest_valid;
    logic [4:0] rob_read_dest_arch_reg_tag;
    logic [5:0] rob_read_safe_phys_reg_tag;
    logic [5:0] rob_read_speculated_phys_reg_tag;
    logic       revert_valid;
    logic [4:0] revert_dest_arch_reg_tag;
    logic [5:0] revert_safe_dest_phys_reg_tag;
    logic [5:0] revert_speculated_dest_phys_reg_tag;
    logic       restore_checkpoint_valid;
    logic       restore_checkpoint_speculate_failed;
    logic [3:0] restore_checkpoint_ROB_index;
    logic [1:0] restore_checkpoint_safe_column;
    logic       restore_checkpoint_success = 1'b0;
    logic       rob_rollback_valid;
    logic [3:0] rob_rollback_tail_index;
    logic       busy;

    logic       rdv   [16];
    logic [4:0] rarch [16];
    logic [5:0] rsafe [16];
    logic [5:0] rspec [16];

    typedef struct packed {
        logic       busy;
        logic       rst_v;
        logic       rst_sf;
        logic [3:0] rst_idx;
        logic [1:0] rst_col;
        logic [3:0] rd_idx;
        logic       rev_v;
        logic [4:0] rev_arch;
        logic [5:0] rev_safe;
        logic [5:0] rev_spec;
        logic       rb_v;
        logic [3:0] rb_tail;
    } obs_t;

    obs_t obs_tr [L];
    obs_t exp_tr [L];
    int   tests = 0;
    int   failed = 0;

    always #5 CLK = ~CLK;

    assign rob_read_dest_valid              = rdv[rob_read_index];
    assign rob_read_dest_arch_reg_tag       = rarch[rob_read_index];
    assign rob_read_safe_phys_reg_tag       = rsafe[rob_read_index];
    assign rob_read_speculated_phys_reg_tag = rspec[rob_read_index];

    map_table_recovery_ctrl dut (
        .CLK(CLK), .RST(RST),
        .resolve_valid(resolve_valid),
        .resolve_mispredict(resolve_mispredict),
        .resolve_ROB_index(resolve_ROB_index),
        .resolve_has_checkpoint(resolve_has_checkpoint),
        .resolve_safe_column(resolve_safe_column),
        .rob_tail_index(rob_tail_index),
        .rob_read_index(rob_read_index),
        .rob_read_dest_valid(rob_read_dest_valid),
        .rob_read_dest_arch_reg_tag(rob_read_dest_arch_reg_tag),
        .rob_read_safe_phys_reg_tag(rob_read_safe_phys_reg_tag),
        .rob_read_speculated_phys_reg_tag(rob_read_speculated_phys_reg_tag),
        .revert_valid(revert_valid),
        .revert_dest_arch_reg_tag(revert_dest_arch_reg_tag),
        .revert_safe_dest_phys_reg_tag(revert_safe_dest_phys_reg_tag),
        .revert_speculated_dest_phys_reg_tag(revert_speculated_dest_phys_reg_tag),
        .restore_checkpoint_valid(restore_checkpoint_valid),
        .restore_checkpoint_speculate_failed(restore_checkpoint_speculate_failed),
        .restore_checkpoint_ROB_index(restore_checkpoint_ROB_index),
        .restore_checkpoint_safe_column(restore_checkpoint_safe_column),
        .restore_checkpoint_success(restore_checkpoint_success),
        .rob_rollback_valid(rob_rollback_valid),
        .rob_rollback_tail_index(rob_rollback_tail_index),
        .busy(busy)
    );

    function automatic obs_t sample();
        obs_t o;
        o.busy     = busy;
        o.rst_v    = restore_checkpoint_valid;
        o.rst_sf   = restore_checkpoint_speculate_failed;
        o.rst_idx  = restore_checkpoint_ROB_index;
        o.rst_col  = restore_checkpoint_safe_column;
        o.rd_idx   = rob_read_index;
        o.rev_v    = revert_valid;
        o.rev_arch = revert_dest_arch_reg_tag;
        o.rev_safe = revert_safe_dest_phys_reg_tag;
        o.rev_spec = revert_speculated_dest_phys_reg_tag;
        o.rb_v     = rob_rollback_valid;
        o.rb_tail  = rob_rollback_tail_index;
        return o;
    endfunction

    task automatic randomize_rob(input int dv_mode);
        for (int i = 0; i < 16; i++) begin
            rdv[i]   = (dv_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(((dv_mode >> i) & 1) != 0);
            rarch[i] = 5'($urandom);
            rsafe[i] = 6'($urandom);
            rspec[i] = 6'($urandom);
        end
    endtask

    // Expected trace from the recovery rules: optional restore, younger entries newest first, rollback.
    task automatic build_exp(input int br, input int tail, input bit mis, input bit ckpt,
                             input bit succ, input int col);
        int k = 0;
        for (int i = 0; i < L; i++) exp_tr[i] = '0;
        if (!mis) begin
            if (ckpt) begin
                exp_tr[0].busy = 1; exp_tr[0].rst_v = 1;
                exp_tr[0].rst_idx = 4'(br); exp_tr[0].rst_col = 2'(col);
            end
            return;
        end
        if (ckpt) begin
            exp_tr[k].busy = 1; exp_tr[k].rst_v = 1; exp_tr[k].rst_sf = 1;
            exp_tr[k].rst_idx = 4'(br); exp_tr[k].rst_col = 2'(col);
            k++;
        end
        if (!(ckpt && succ)) begin
            int n = (tail + 15 - br) % 16;
            for (int j = 0; j < n; j++) begin
                int e = (tail + 15 - j) % 16;
                exp_tr[k].busy = 1; exp_tr[k].rd_idx = 4'(e);
                exp_tr[k].rev_v = rdv[e]; exp_tr[k].rev_arch = rarch[e];
                exp_tr[k].rev_safe = rsafe[e]; exp_tr[k].rev_spec = rspec[e];
                k++;
            end
        end
        exp_tr[k].busy = 1; exp_tr[k].rb_v = 1; exp_tr[k].rb_tail = 4'((br + 1) % 16);
    endtask

    task automatic run_recovery(input int br, input int tail, input bit mis, input bit ckpt,
                                input bit succ, input int col);
        @(negedge CLK);
        resolve_valid = 1; resolve_mispredict = mis; resolve_ROB_index = 4'(br);
        resolve_has_checkpoint = ckpt; resolve_safe_column = 2'(col);
        rob_tail_index = 4'(tail); restore_checkpoint_success = succ;
        @(posedge CLK); #1;
        resolve_valid = 0;
        for (int i = 0; i < L; i++) begin
            obs_tr[i] = sample();
            @(posedge CLK); #1;
        end
        build_exp(br, tail, mis, ckpt, succ, col);
    endtask

    task automatic test_reset();
        RST = 1; resolve_valid = 0; rob_tail_index = 4'($urandom);
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK); #1;
            tests++;
            if (sample() !== obs_t'(0)) begin
                failed++; $display("FAIL reset cycle %0d: got %h expected 0", c, sample());
            end
        end
        @(negedge CLK); RST = 0;
    endtask

    task automatic test_correct_predict();
        randomize_rob(-1);
        run_recovery(3, 9, 0, 1, 1, 1);
        for (int i = 0; i < L; i++) begin
            tests++;
            if (obs_tr[i] !== exp_tr[i]) begin
                failed++; $display("FAIL correct_predict cycle %0d: got %h expected %h", i, obs_tr[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_mispredict_restore();
        randomize_rob(-1);
        run_recovery(5, 11, 1, 1, 1, 2);
        for (int i = 0; i < L; i++) begin
            tests++;
            if (obs_tr[i] !== exp_tr[i]) begin
                failed++; $display("FAIL mispredict_restore cycle %0d: got %h expected %h", i, obs_tr[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_failed_restore_walk();
        randomize_rob((1 << 8) | (1 << 6));
        run_recovery(5, 9, 1, 1, 0, 3);
        for (int i = 0; i < L; i++) begin
            tests++;
            if (obs_tr[i] !== exp_tr[i]) begin
                failed++; $display("FAIL failed_restore_walk cycle %0d: got %h expected %h", i, obs_tr[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_wrap_walk();
        randomize_rob(-1);
        run_recovery(14, 2, 1, 0, 0, 0);
        for (int i = 0; i < L; i++) begin
            tests++;
            if (obs_tr[i] !== exp_tr[i]) begin
                failed++; $display("FAIL wrap_walk cycle %0d: got %h expected %h", i, obs_tr[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_empty_walk();
        randomize_rob(16'hffff);
        run_recovery(7, 8, 1, 0, 0, 1);
        for (int i = 0; i < L; i++) begin
            tests++;
            if (obs_tr[i] !== exp_tr[i]) begin
                failed++; $display("FAIL empty_walk cycle %0d: got %h expected %h", i, obs_tr[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        randomize_rob(16'hffff);
        @(negedge CLK);
        resolve_valid = 1; resolve_mispredict = 1; resolve_ROB_index = 4'd0;
        resolve_has_checkpoint = 0; rob_tail_index = 4'd0;
        @(posedge CLK); #1;
        resolve_valid = 0;
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if (revert_valid !== 1'b1 || busy !== 1'b1) begin
            failed++; $display("FAIL mid_walk_active: got revert=%b busy=%b expected 1 1", revert_valid, busy);
        end
        @(negedge CLK); RST = 1;
        @(posedge CLK); #1;
        tests++;
        if (revert_valid !== 1'b0 || busy !== 1'b0) begin
            failed++; $display("FAIL reset_mid_walk: got revert=%b busy=%b expected 0 0", revert_valid, busy);
        end
        @(negedge CLK); RST = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            tests++;
            if (sample() !== obs_t'(0)) begin
                failed++; $display("FAIL after_reset_mid_walk cycle %0d: got %h expected 0", c, sample());
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit mis  = 1'($urandom_range(0, 1));
            bit ckpt = 1'($urandom_range(0, 1));
            bit succ = (!mis && ckpt) ? 1'b1 : 1'($urandom_range(0, 1));
            randomize_rob(-1);
            run_recovery(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), mis, ckpt, succ,
                         int'($urandom_range(0, 3)));
            for (int i = 0; i < L; i++) begin
                tests++;
                if (obs_tr[i] !== exp_tr[i]) begin
                    failed++; $display("FAIL random case %0d cycle %0d: got %h expected %h", t, i, obs_tr[i], exp_tr[i]);
                end
            end
        end
    endtask

    initial begin
        randomize_rob(0);
        test_reset();
        test_correct_predict();
        test_mispredict_restore();
        test_failed_restore_walk();
        test_wrap_walk();
        test_empty_walk();
        test_reset_mid_walk();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/map_table_recovery_ctrl.md
Name: map_table_recovery_ctrl

Overview:
Initiator-side controller for the physical register map table's recovery interface. On branch resolution it sequences map table operations. A correct prediction frees the checkpoint column. A mispredict restores the checkpoint, and if that restore is refused it falls back to a backward ROB walk that reverts renames one per cycle. It then signals the ROB to roll back its tail and holds dispatch stalled (busy) for the whole recovery.

Parameters:
NUM_ARCH_REGS, 32, architectural registers; arch tag width AW = log2 = 5
NUM_PHYS_REGS, 64, physical registers; phys tag width PW = log2 = 6
ROB_DEPTH, 16, ROB entries, power of 2; ROB index width RW = log2 = 4
CHECKPOINT_COLUMNS, 4, map table checkpoint columns; column width CW = log2 = 2

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
resolve_valid  in  1  branch resolved this cycle
resolve_mispredict  in  1  1 = mispredicted
resolve_ROB_index  in  RW  ROB index of branch
resolve_has_checkpoint  in  1  branch saved a map table checkpoint
resolve_safe_column  in  CW  safe column returned at checkpoint save
rob_tail_index  in  RW  next ROB allocate index (youngest + 1)
rob_read_index  out  RW  walk read address, combinational ROB read
rob_read_dest_valid  in  1  entry at rob_read_index wrote a dest reg
rob_read_dest_arch_reg_tag  in  AW  that entry's arch dest
rob_read_safe_phys_reg_tag  in  PW  previous (safe) mapping
rob_read_speculated_phys_reg_tag  in  PW  mapping the entry installed
revert_valid  out  1  map table revert request
revert_dest_arch_reg_tag  out  AW
revert_safe_dest_phys_reg_tag  out  PW
revert_speculated_dest_phys_reg_tag  out  PW
restore_checkpoint_valid  out  1  map table restore request
restore_checkpoint_speculate_failed  out  1
restore_checkpoint_ROB_index  out  RW
restore_checkpoint_safe_column  out  CW
restore_checkpoint_success  in  1  same-cycle response from map table
rob_rollback_valid  out  1  one-cycle pulse: ROB sets tail
rob_rollback_tail_index  out  RW  = branch index + 1 (mod ROB_DEPTH)
busy  out  1  recovery in progress; dispatch/rename must stall

Behaviour:
- States: IDLE, FREE_CKPT, RESTORE, WALK, DONE. All outputs are 0 in reset and in IDLE.
- Reset: when RST is high at a CLK edge, state goes to IDLE and all latched registers clear. Reset mid-operation abandons the sequence with no further requests.
- Latched registers on accept: br_idx, safe_col, walk_ptr.
- IDLE, resolve_valid=0: stay in IDLE.
- IDLE, resolve_valid & ~mispredict & has_checkpoint: go to FREE_CKPT.
- IDLE, resolve_valid & ~mispredict & ~has_checkpoint: no action.
- IDLE, resolve_valid & mispredict & has_checkpoint: go to RESTORE.
- IDLE, resolve_valid & mispredict & ~has_checkpoint:
  - walk_ptr = rob_tail_index-1.
  - If walk_ptr == br_idx, go to DONE; otherwise go to WALK.
- FREE_CKPT (1 cycle): restore_checkpoint_valid=1, speculate_failed=0, ROB_index=br_idx, safe_column=safe_col. Go to IDLE. No rollback pulse. success=0 here is a protocol error and must be asserted.
- RESTORE:
  - Drives restore_checkpoint_valid=1, speculate_failed=1, ROB_index=br_idx, safe_column=safe_col.
  - success=1: go to DONE.
  - success=0 (tag mismatch): walk_ptr = rob_tail_index-1, using the tail sampled in this state. If walk_ptr == br_idx, go to DONE; otherwise go to WALK.
- WALK:
  - rob_read_index = walk_ptr.
  - revert_valid = rob_read_dest_valid, with fields passed straight through from the rob_read_* inputs.
  - If walk_ptr == br_idx+1, go to DONE; otherwise walk_ptr decrements mod ROB_DEPTH (15 follows 0).
  - One entry per cycle, youngest first. The branch entry itself is never reverted.
- DONE (1 cycle): rob_rollback_valid=1, tail=br_idx+1 mod ROB_DEPTH. Go to IDLE.
- busy = (state != IDLE). resolve_valid while busy is ignored; upstream guarantees it is 0, and an assertion checks this.
- Latency:
  - Checkpoint restore: resolve at cycle 0, restore request at cycle 1, rollback pulse at cycle 2.
  - Walk with N younger entries: N WALK cycles, then DONE.
  - Empty walk (N=0): resolve at cycle 0, rollback pulse at cycle 1.
- Never drives revert_valid and restore_checkpoint_valid in the same cycle.
- Index arithmetic is RW-bit, wraps naturally.

Test Plan:
- Reset with RST=1 for 2 cycles -> all outputs 0, busy=0.
- Correct prediction: resolve br_idx=3, has_checkpoint=1, safe_column=1 -> next cycle restore_valid=1, speculate_failed=0, column=1; no rollback pulse; busy for 1 cycle.
- Mispredict with checkpoint: br_idx=5, column=2, success=1 -> cycle 1 restore_valid with speculate_failed=1, ROB_index=5; cycle 2 rollback_valid with tail=6; busy for 2 cycles.
- Failed restore with walk: br_idx=5, tail=9, success=0, dest_valid=1 for entries 8 and 6 only -> read index sequence 8, 7, 6; revert_valid pattern 1, 0, 1 with fields matching the ROB inputs; then rollback with tail=6.
- Wrap-around walk: br_idx=14, tail=2, no checkpoint -> read index sequence 1, 0, 15; rollback with tail=15.
- Empty walk: br_idx=7, tail=8, no checkpoint -> no reverts, rollback tail=8 on the cycle after resolve. Separately, asserting RST during WALK -> revert_valid=0 and busy=0 on the next cycle.
